// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pipe_pkg
// Purpose  : Shared types and constants for the pipeline stage registers.
//            Provides the occupancy state encoding, zero constants and the
//            standard ID/EX bundle widths used by the instantiating stages.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

  // Occupancy of one stage register: nothing held, main only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic        ZERO      = 1'b0;

  // Standard ID/EX bundle: pc, imme, Rd_data1, Rd_data2 on the datapath side;
  // ALUSrc/ALUctl/branch/jump/mem/writeback flags on the control side.
  localparam int unsigned XLEN         = 32;
  localparam int unsigned ID_EX_DATA_W = 4 * XLEN;
  localparam int unsigned ID_EX_CTRL_W = 24;

endpackage : riscv_pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_entry
// Purpose  : One valid + data + ctrl register slice of a pipeline stage
//            register. Used as the main entry and, optionally, the skid entry.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            load_i            - capture data_i/ctrl_i and mark valid
//            clear_i           - drop the valid bit (payload is kept)
//            data_i, ctrl_i    - payload to capture
//            valid_o, data_o, ctrl_o - held contents
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_entry
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clear only drops the valid bit: the payload stays stale, and the
  // consumer is responsible for masking anything that must not leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= ZERO;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clear_i) begin
      valid_q <= ZERO;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule : pipe_stage_entry
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised inter-stage pipeline register with valid/ready
//            handshake, hazard stall, branch/jump flush, optional skid entry
//            and saturating stall/bubble performance counters.
// Ports    : clk, rst                      - clock, sync active-high reset
//            in_valid, in_ready            - upstream handshake
//            in_data, in_ctrl              - incoming datapath/control bundle
//            stall, flush                  - hazard stall, redirect flush
//            out_valid, out_ready          - downstream handshake
//            out_data, out_ctrl            - held bundle (ctrl zero if bubble)
//            stall_cnt, bubble_cnt         - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int CTRL_W  = 24,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_state_e state_q, state_d;

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clear;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clear;

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid_ready
      // Registered backpressure: only the skid occupancy gates acceptance,
      // so in_ready never depends combinationally on out_ready.
      assign in_ready = ~skid_valid & ~stall;
    end else begin : g_direct_ready
      assign in_ready = (~out_valid | out_ready) & ~stall;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Occupancy FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;

    if (flush) begin
      // Redirect: drop everything held and whatever is arriving this cycle.
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            // Only reachable with a skid entry: without one, in_fire while
            // holding an entry implies out_ready.
            if (SKID_EN != 0) begin
              skid_load = 1'b1;
              state_d   = ST_TWO;
            end
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so the only event is a drain of main.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  // The skid entry is always older than the input, so it has priority.
  assign main_data_d = main_from_skid ? skid_data : in_data;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_stage_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_d),
    .ctrl_i  (main_ctrl_d),
    .valid_o (main_valid),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
      );
    end else begin : g_no_skid
      logic unused_skid_ctl;
      assign unused_skid_ctl = skid_load ^ skid_clear;
      assign skid_valid      = 1'b0;
      assign skid_data       = '0;
      assign skid_ctrl       = '0;
    end
  endgenerate

  assign out_data = main_data;
  // A bubble must never carry MemWrite/RegWrite downstream.
  assign out_ctrl = main_valid ? main_ctrl : '0;

  // --------------------------------------------------------------------------
  // Performance counters (saturating, cleared only by reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (!out_valid && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Two instances share the
//            same stimulus: A with a skid entry and 16-bit counters, B without
//            a skid entry and 4-bit counters. A queue-style reference model
//            tracks each instance's held instructions and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int CW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          stall;
  logic          flush;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  logic [15:0]   a_stall_cnt, a_bubble_cnt;

  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  logic [3:0]    b_stall_cnt, b_bubble_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
  );

  // --------------------------------------------------------------------------
  // Reference model: per instance, an ordered list of held instructions
  // (oldest first), the last payload that sat at the head, and counters.
  // Index 0 models instance A (capacity 2), index 1 instance B (capacity 1).
  // --------------------------------------------------------------------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] md     [2][2];
  logic [CW-1:0] mc     [2][2];
  int            mn     [2];
  logic [DW-1:0] mstale [2];
  int            mstall [2];
  int            mbub   [2];
  int            cmax   [2];

  function automatic logic m_in_ready(int k);
    if (k == 0) return (mn[0] < 2) && !stall;
    return ((mn[1] == 0) || out_ready) && !stall;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic rdy;
      logic ov;
      rdy = m_in_ready(k);
      ov  = (mn[k] > 0);
      if (rst) begin
        mn[k] = 0; mstale[k] = '0; mstall[k] = 0; mbub[k] = 0;
      end else begin
        if (ov && !out_ready && mstall[k] < cmax[k]) mstall[k] = mstall[k] + 1;
        if (!ov && mbub[k] < cmax[k]) mbub[k] = mbub[k] + 1;
        if (flush) begin
          mn[k] = 0;
        end else begin
          if (ov && out_ready) begin
            md[k][0] = md[k][1]; mc[k][0] = mc[k][1]; mn[k] = mn[k] - 1;
          end
          if (in_valid && rdy) begin
            md[k][mn[k]] = in_data; mc[k][mn[k]] = in_ctrl; mn[k] = mn[k] + 1;
          end
        end
        if (mn[k] > 0) mstale[k] = md[k][0];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("A.out_valid",  DW'(a_out_valid), DW'(mn[0] > 0));
    chk("A.out_data",   a_out_data, (mn[0] > 0) ? md[0][0] : mstale[0]);
    chk("A.out_ctrl",   DW'(a_out_ctrl), DW'((mn[0] > 0) ? mc[0][0] : '0));
    chk("A.in_ready",   DW'(a_in_ready), DW'(m_in_ready(0)));
    chk("A.stall_cnt",  DW'(a_stall_cnt), DW'(mstall[0]));
    chk("A.bubble_cnt", DW'(a_bubble_cnt), DW'(mbub[0]));
    chk("B.out_valid",  DW'(b_out_valid), DW'(mn[1] > 0));
    chk("B.out_data",   b_out_data, (mn[1] > 0) ? md[1][0] : mstale[1]);
    chk("B.out_ctrl",   DW'(b_out_ctrl), DW'((mn[1] > 0) ? mc[1][0] : '0));
    chk("B.in_ready",   DW'(b_in_ready), DW'(m_in_ready(1)));
    chk("B.stall_cnt",  DW'(b_stall_cnt), DW'(mstall[1]));
    chk("B.bubble_cnt", DW'(b_bubble_cnt), DW'(mbub[1]));
  endtask

  task automatic look();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    look();
    tick();
  endtask

  task automatic put(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = CW'($urandom());
  endtask

  int exp_bub;

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data = '0; in_ctrl = '0;
    cmax[0] = 65535; cmax[1] = 15;
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mstale[k] = '0; mstall[k] = 0; mbub[k] = 0;
      md[k][0] = '0; md[k][1] = '0; mc[k][0] = '0; mc[k][1] = '0;
    end

    // Reset: two cycles, then check the documented reset values.
    tick();
    look();
    chk("reset.out_valid", DW'(a_out_valid), '0);
    chk("reset.out_data",  a_out_data, '0);
    chk("reset.in_ready",  DW'(a_in_ready), DW'(1'b1));
    chk("reset.bubble",    DW'(a_bubble_cnt), '0);
    tick();
    rst = 1'b0;

    // Streaming 0x1..0x8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      put(DW'(i));
      cyc();
    end
    in_valid = 1'b0;
    look();
    chk("stream.last_out",  a_out_data, DW'(8));
    chk("stream.bubble_A",  DW'(a_bubble_cnt), DW'(1));
    chk("stream.bubble_B",  DW'(b_bubble_cnt), DW'(1));
    tick();
    cyc();

    // Backpressure into the skid entry, then release.
    out_ready = 1'b1; put(DW'('hA)); cyc();
    out_ready = 1'b0; put(DW'('hB)); cyc();
    put(DW'('hC));
    look();
    chk("bp.two_in_ready", DW'(a_in_ready), '0);
    chk("bp.two_main",     a_out_data, DW'('hA));
    tick();
    cyc();
    out_ready = 1'b1; cyc();
    look();
    chk("bp.skid_moved",   a_out_data, DW'('hB));
    tick();
    in_valid = 1'b0; cyc(); cyc();

    // Flush while holding two entries with a new input on offer.
    out_ready = 1'b1; put(DW'('hD1)); cyc();
    out_ready = 1'b0; put(DW'('hD2)); cyc();
    put(DW'('hD3)); flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0;
    look();
    chk("flush.out_valid", DW'(a_out_valid), '0);
    chk("flush.out_ctrl",  DW'(a_out_ctrl), '0);
    chk("flush.in_ready",  DW'(a_in_ready), DW'(1'b1));
    tick();
    out_ready = 1'b1; cyc(); cyc();

    // Hazard stall for three cycles while an entry drains.
    put(DW'('h50)); cyc();
    stall = 1'b1; put(DW'('h51));
    exp_bub = mbub[0] + 2;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("stall.in_ready", DW'(a_in_ready), '0);
      tick();
    end
    stall = 1'b0;
    look();
    chk("stall.bubble", DW'(a_bubble_cnt), DW'(exp_bub));
    tick();
    in_valid = 1'b0; cyc();

    // No-skid instance: out_ready low drops in_ready in the same cycle,
    // and a long hold saturates the 4-bit stall counter.
    put(DW'('h60)); cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    look();
    chk("noskid.in_ready", DW'(b_in_ready), '0);
    tick();
    for (int i = 0; i < 20; i++) cyc();
    look();
    chk("noskid.sat", DW'(b_stall_cnt), DW'(15));
    tick();
    out_ready = 1'b1; cyc(); cyc();

    // Randomised traffic including a mid-operation reset.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_ctrl   = CW'($urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = (i == 200);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire
